quad_mag_comparator: RTL and testbench
======================================

Name: quad_mag_comparator

Overview:
- Registered 4-bit unsigned magnitude comparator with cascade inputs, in the style of the 7485.
- Compares operands a and b. When they are equal, the cascade inputs from a less-significant stage decide the result, so stages chain into wider comparators.
- Outputs are registered on one clock, giving one cycle of latency.
- Used wherever a one-hot greater / less / equal flag triple is needed from two nibbles.

Parameters:
- WIDTH, 4, operand width in bits. Only 4 is required to be supported; other values are not verified.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; clears the output registers
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- eq_in  input  1  cascade equal from the less-significant stage
- lt_in  input  1  cascade less-than from the less-significant stage
- gt_in  input  1  cascade greater-than from the less-significant stage
- gt_out  output  1  registered: A greater than B
- lt_out  output  1  registered: A less than B
- eq_out  output  1  registered: A equal to B, including cascade

Interface decision (already decided):
- One clock; reset is asynchronous and active-high.
- Clock port is clk, reset port is rst.
- Port order after clk and rst: a, b, eq_in, lt_in, gt_in, gt_out, lt_out, eq_out.

Behaviour:
- Reset:
  - While rst=1, gt_out=0, lt_out=0, eq_out=0, immediately and independent of clk.
  - The first result appears on the first rising clk edge after rst deasserts.
- Latency:
  - Inputs are sampled on the rising clk edge; outputs reflect them from that edge onward, one cycle of latency.
  - No handshake; a new comparison every cycle.
- Combinational next-state, decided MSB first:
  - a > b (unsigned): gt=1, lt=0, eq=0.
  - a < b: gt=0, lt=1, eq=0.
  - a == b and eq_in=1: gt=0, lt=0, eq=1. eq_in has priority over lt_in and gt_in.
  - a == b and eq_in=0: gt=gt_in, lt=lt_in, eq=0. Cascade passes through, so the illegal combination gt_in=lt_in=1 yields both outputs 1.
  - a == b and all cascade inputs 0: all outputs 0.
- Stand-alone use ties eq_in=1, lt_in=0, gt_in=0. Outputs are then exactly one-hot after the first clocked cycle.
- Operand-only decisions ignore the cascade inputs entirely. Boundaries such as 0 vs 15 and 15 vs 15 follow the rules above.
- No X-propagation masking. Unknown inputs may produce unknown outputs.
- The internal combinational core is shared with the bit cells described below. Structural and dataflow formulations must agree bit-exactly.

Decomposition:
- Shared package cmp_pkg:
  - typedef cmp_res_t, a 3-bit struct {gt, lt, eq}.
  - Constants CMP_GT, CMP_LT, CMP_EQ, CMP_NONE.
  - Constant CMP_WIDTH=4.
- One sub-module, cmp_bit_cell:
  - Combinational 1-bit compare with cascade: inputs ai, bi and the higher-priority decision; output the updated decision.
  - Instantiated WIDTH times, MSB to LSB, in a generate loop.
  - The final stage merges eq_in, lt_in and gt_in per the rules above.
- The top module holds only the three output flops and the reset logic.

Test Plan:
- rst=1, then any inputs -> gt_out=lt_out=eq_out=0. Assert rst mid-run with outputs valid -> outputs clear immediately without waiting for clk.
- a=1111, b=1101, eq_in=1, lt_in=0, gt_in=0 -> after one clk: gt_out=1, lt_out=0, eq_out=0.
- Same cascade, sequence of a/b pairs (one per clk) -> results one cycle behind:
  - a=1101, b=1101 -> eq_out=1
  - a=1001, b=1101 -> lt_out=1
  - a=1101, b=1101 -> eq_out=1
  - a=1101, b=1000 -> gt_out=1
  - a=1101, b=1111 -> lt_out=1
- a=b=0101 with cascade inputs:
  - eq_in=0, gt_in=1 -> gt_out=1
  - eq_in=0, lt_in=1 -> lt_out=1
  - eq_in=1, gt_in=1 -> eq_out=1 only
  - all cascade 0 -> all outputs 0
- a=0000, b=1111 with gt_in=1, eq_in=0 -> lt_out=1, gt_out=0 (cascade ignored).
- Exhaustive 256 a/b pairs × 8 cascade combinations over consecutive clocks -> every registered result matches the reference model one cycle later.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and helpers for the cascadable magnitude comparator.
// Result triple is ordered {gt, lt, eq}, one bit each.
package cmp_pkg;

   localparam int unsigned CMP_WIDTH = 4;

   typedef struct packed {
      logic gt;
      logic lt;
      logic eq;
   } cmp_res_t;

   localparam cmp_res_t CMP_GT   = 3'b100;
   localparam cmp_res_t CMP_LT   = 3'b010;
   localparam cmp_res_t CMP_EQ   = 3'b001;
   localparam cmp_res_t CMP_NONE = 3'b000;

   // Operands tie: eq_in wins, otherwise gt_in/lt_in pass straight through.
   function automatic cmp_res_t cmp_merge(input cmp_res_t chain,
                                          input logic     eq_in,
                                          input logic     lt_in,
                                          input logic     gt_in);
      cmp_res_t res;
      res = chain;
      if (chain.eq) begin
         if (eq_in) begin
            res = CMP_EQ;
         end else begin
            res.gt = gt_in;
            res.lt = lt_in;
            res.eq = 1'b0;
         end
      end
      return res;
   endfunction

endpackage : cmp_pkg

// File: rtl/cmp_bit_cell.sv
// One bit of the MSB-first compare chain: keeps an earlier decision,
// otherwise resolves on this bit pair.
module cmp_bit_cell
   import cmp_pkg::*;
(
   input  logic     ai,
   input  logic     bi,
   input  cmp_res_t dec_in,
   output cmp_res_t dec_out
);

   always_comb begin
      dec_out = dec_in;
      if (dec_in.eq) begin
         if (ai & ~bi) begin
            dec_out = CMP_GT;
         end else if (~ai & bi) begin
            dec_out = CMP_LT;
         end else begin
            dec_out = CMP_EQ;
         end
      end
   end

endmodule : cmp_bit_cell

// File: rtl/quad_mag_comparator.sv
// Registered 4-bit magnitude comparator with 7485-style cascade inputs.
// One cycle of latency; outputs clear asynchronously on rst.
module quad_mag_comparator
   import cmp_pkg::*;
#(
   parameter int unsigned WIDTH = CMP_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             eq_in,
   input  logic             lt_in,
   input  logic             gt_in,
   output logic             gt_out,
   output logic             lt_out,
   output logic             eq_out
);

   // chain[WIDTH] seeds "equal so far"; chain[0] is the operand-only decision.
   cmp_res_t chain [WIDTH:0];
   cmp_res_t res_d;
   cmp_res_t res_q;

   assign chain[WIDTH] = CMP_EQ;

   for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_cell
      cmp_bit_cell u_cell (
         .ai      (a[i]),
         .bi      (b[i]),
         .dec_in  (chain[i+1]),
         .dec_out (chain[i])
      );
   end

   always_comb begin
      res_d = CMP_NONE;
      res_d = cmp_merge(chain[0], eq_in, lt_in, gt_in);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_q <= CMP_NONE;
      end else begin
         res_q <= res_d;
      end
   end

   assign gt_out = res_q.gt;
   assign lt_out = res_q.lt;
   assign eq_out = res_q.eq;

endmodule : quad_mag_comparator

// File: tb/tb_quad_mag_comparator.sv
// Directed and exhaustive checks of quad_mag_comparator against a
// behavioural reference; results compared as {gt, lt, eq}.
module tb_quad_mag_comparator;

   logic       clk;
   logic       rst;
   logic [3:0] a;
   logic [3:0] b;
   logic       eq_in;
   logic       lt_in;
   logic       gt_in;
   logic       gt_out;
   logic       lt_out;
   logic       eq_out;

   int n_tests;
   int n_fail;

   quad_mag_comparator #(.WIDTH(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .a      (a),
      .b      (b),
      .eq_in  (eq_in),
      .lt_in  (lt_in),
      .gt_in  (gt_in),
      .gt_out (gt_out),
      .lt_out (lt_out),
      .eq_out (eq_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_res(input string tag, input logic [2:0] got, input logic [2:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got gt/lt/eq=%b expected %b", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] ref_model(input logic [3:0] ra, input logic [3:0] rb,
                                            input logic re, input logic rl, input logic rg);
      if (ra > rb)      return 3'b100;
      else if (ra < rb) return 3'b010;
      else if (re)      return 3'b001;
      else              return {rg, rl, 1'b0};
   endfunction

   task automatic drive(input logic [3:0] va, input logic [3:0] vb,
                        input logic ve, input logic vl, input logic vg);
      a = va; b = vb; eq_in = ve; lt_in = vl; gt_in = vg;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] outs();
      return {gt_out, lt_out, eq_out};
   endfunction

   initial begin
      n_tests = 0;
      n_fail  = 0;

      rst = 1'b1;
      drive(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0);
      #2;
      check_res("reset_async", outs(), 3'b000);
      step();
      step();
      check_res("reset_held_clk", outs(), 3'b000);
      rst = 1'b0;
      drive(4'b1111, 4'b1101, 1'b1, 1'b0, 1'b0);
      #1;
      check_res("pre_first_edge", outs(), 3'b000);
      step();
      check_res("gt_1111_1101", outs(), 3'b100);

      // Outputs must hold until the next edge even with new inputs present.
      drive(4'b1101, 4'b1101, 1'b1, 1'b0, 1'b0);
      #1;
      check_res("hold_until_edge", outs(), 3'b100);
      step();
      check_res("seq_eq_1", outs(), 3'b001);
      drive(4'b1001, 4'b1101, 1'b1, 1'b0, 1'b0); step();
      check_res("seq_lt_1", outs(), 3'b010);
      drive(4'b1101, 4'b1101, 1'b1, 1'b0, 1'b0); step();
      check_res("seq_eq_2", outs(), 3'b001);
      drive(4'b1101, 4'b1000, 1'b1, 1'b0, 1'b0); step();
      check_res("seq_gt", outs(), 3'b100);
      drive(4'b1101, 4'b1111, 1'b1, 1'b0, 1'b0); step();
      check_res("seq_lt_2", outs(), 3'b010);

      drive(4'b0101, 4'b0101, 1'b0, 1'b0, 1'b1); step();
      check_res("casc_gt", outs(), 3'b100);
      drive(4'b0101, 4'b0101, 1'b0, 1'b1, 1'b0); step();
      check_res("casc_lt", outs(), 3'b010);
      drive(4'b0101, 4'b0101, 1'b1, 1'b0, 1'b1); step();
      check_res("casc_eq_prio", outs(), 3'b001);
      drive(4'b0101, 4'b0101, 1'b0, 1'b0, 1'b0); step();
      check_res("casc_none", outs(), 3'b000);
      drive(4'b0101, 4'b0101, 1'b0, 1'b1, 1'b1); step();
      check_res("casc_illegal", outs(), 3'b110);
      drive(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1); step();
      check_res("lt_0_15_casc_ign", outs(), 3'b010);
      drive(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0); step();
      check_res("eq_15_15", outs(), 3'b001);
      drive(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0); step();
      check_res("gt_15_0_casc_ign", outs(), 3'b100);

      // Mid-run reset clears outputs between edges.
      #2;
      rst = 1'b1;
      #1;
      check_res("reset_mid_async", outs(), 3'b000);
      step();
      check_res("reset_mid_held", outs(), 3'b000);
      #1;
      rst = 1'b0;
      drive(4'b0011, 4'b0010, 1'b1, 1'b0, 1'b0);
      step();
      check_res("post_reset_gt", outs(), 3'b100);

      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            for (int ic = 0; ic < 8; ic++) begin
               logic [2:0] casc;
               logic [2:0] exp;
               casc = 3'(ic);
               drive(4'(ia), 4'(ib), casc[2], casc[1], casc[0]);
               exp = ref_model(4'(ia), 4'(ib), casc[2], casc[1], casc[0]);
               step();
               check_res($sformatf("exh_a%0d_b%0d_c%0d", ia, ib, ic), outs(), exp);
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_quad_mag_comparator
